// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised serial input, mid-bit sampling, 8N1-style framing
// with a sticky framing-error flag and a per-sample baud tick.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              rcv,
    output logic              error,
    output logic              clk_baud
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_DIV_END  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state;
    logic              rx_m;
    logic              rx_s;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;

    // Metastability guard; both flops idle high like the line itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Frame FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            data     <= '0;
            rcv      <= 1'b0;
            error    <= 1'b0;
            clk_baud <= 1'b0;
        end else begin
            rcv      <= 1'b0;
            clk_baud <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == CNT_HALF_END) begin
                        clk_baud <= 1'b1;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_DIV_END) begin
                        clk_baud       <= 1'b1;
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == IDX_LAST) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_DIV_END) begin
                        clk_baud <= 1'b1;
                        cnt      <= '0;
                        if (rx_s) begin
                            data  <= shreg;
                            rcv   <= 1'b1;
                            error <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            error <= 1'b1;
                            state <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Wait out a held-low line so it is not decoded as a stream of frames.
                S_BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
